j17_control_unit: RTL and testbench
===================================

# j17_control_unit

Multi-cycle sequencer for the J17 datapath. Fetches a 32-bit instruction from instruction memory over a req/ack handshake, decodes it, and drives the datapath control lines (alucode, op1, op2, imControl, regenable, ramenable, pcControl, writecode) through a fixed state sequence. It also issues exactly one PC-advance strobe per retired instruction, halts on HALT or an illegal opcode, and counts retired instructions.

## Interface
- Parameters:
- `XLEN`, 32: instruction and PC width.
- `CNT_W`, 32: retired-instruction counter width.
- Ports:
- `clock` in 1: processor clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: level; leave IDLE or HALT and begin fetching.
- `pc` in XLEN: current datapath PC.
- `imem_req` out 1: fetch request.
- `imem_addr` out 10: `pc[9:0]`, registered at request.
- `imem_ack` in 1: instruction valid this cycle.
- `imem_data` in 32: instruction word.
- `alucode` out 5, `op1` out 5, `op2` out 20, `imControl` out 1: datapath controls.
- `regenable` out 1, `ramenable` out 2, `writecode` out 2, `pcControl` out 3: datapath controls.
- `pc_step` out 1: one-cycle strobe; datapath adds pcjump only when high.
- `halted` out 1: in HALT.
- `illegal` out 1: sticky; halt cause was an undefined opcode.
- `retired` out CNT_W: instructions completed.

## Operation
- Format: `[31:27]` opcode, `[26:22]` op1, `[19:0]` op2. Bits `[21:20]` are ignored.
- Decode map:
- 0x00–0x0B: register ALU op. alucode=opcode, imControl=0, writecode=0.
- 0x0C ADDI: alucode=1, imControl=1, writecode=0.
- 0x0D LOAD: ramenable=01, imControl=1, writecode=1, MEM state.
- 0x0E STORE: ramenable=10, MEM state, no write-back.
- 0x10–0x17: branch. pcControl=opcode[2:0], no write-back.
- 0x1F: HALT.
- Anything else: illegal. Set `illegal`, go to HALT.
- States and transitions:
- IDLE → FETCH on `start`.
- FETCH: assert `imem_req` until `imem_ack`; latch `imem_data` into IR; go to DECODE.
- DECODE: drive decoded controls from IR.
  - Branch → EXEC.
  - LOAD/STORE → MEM.
  - ALU → WB.
  - HALT or illegal → HALT.
- MEM: hold ramenable one cycle for the RAM read/write. LOAD → WB; STORE → EXEC.
- WB: `regenable`=1 for exactly one cycle → EXEC.
- EXEC: `pc_step`=1. pcControl = decoded value for branches, 0 otherwise. Increment `retired`. Go to FETCH.
- HALT: `halted`=1. `start` clears `illegal` and goes to FETCH.
- Outside their owning state, `regenable`, `ramenable`, `pc_step` and `imem_req` are 0. The other controls hold their decoded values from DECODE through EXEC.
- `retired` wraps modulo 2^CNT_W.

## Timing
- Reset (async) values:
  - state=IDLE; IR=0.
  - `imem_req`=0, `imem_addr`=0.
  - all datapath controls 0; `pc_step`=0.
  - `halted`=0, `illegal`=0, `retired`=0.
- All outputs are registered, changing on the rising `clock` edge.
- Cycles with zero-wait fetch (ack in the first FETCH cycle):
  - ALU/ADDI: 4 (FETCH, DECODE, WB, EXEC).
  - LOAD: 5.
  - STORE: 4.
  - Branch: 3.
- Each fetch wait cycle adds 1.
- `imem_ack` is ignored outside FETCH.
- `imem_addr` is sampled from `pc` on FETCH entry and held until ack.
- `pc_step` never coincides with `regenable`, so the write-back completes before the PC changes.
- Reset asserted mid-instruction aborts immediately: no partial `regenable` or `pc_step` pulse follows, and `retired` is not incremented.
- `start` held high in EXEC has no effect.

## Structure
- Shared package `j17_pkg`:
  - opcode constants: OP_ADDI, OP_LOAD, OP_STORE, OP_BR_BASE, OP_HALT.
  - state enum.
  - alucode constants 0–11.
  - pcControl and writecode encodings.
- One combinational sub-module, `j17_decoder`: IR → control bundle plus class flags (is_alu, is_mem, is_load, is_branch, is_halt, is_illegal).
- The FSM, registers and counter live in `j17_control_unit`.

## Test plan
- Reset mid-FETCH with `imem_req`=1 → next cycle all outputs are at reset values and state is IDLE.
- `start`, instruction 0x0840_0000 (opcode 1 ADD, op1=1), ack after 2 wait cycles → regenable=1 exactly once, alucode=1, imControl=0, pc_step 1 cycle after regenable, retired=1, total 6 cycles.
- LOAD (opcode 0x0D, op2=0x00005) → ramenable=01 for one cycle, then regenable=1 with writecode=1, then pc_step; 5 cycles at zero wait.
- Branch opcode 0x12 → pcControl=2 during the pc_step cycle, regenable and ramenable stay 0, 3 cycles.
- Opcode 0x1B → halted=1, illegal=1, no pc_step, retired unchanged. `start` → illegal=0, fetch resumes.
- Preload `retired`=2^CNT_W−1 (CNT_W=4 build), retire one instruction → retired=0.

Source files
------------

// File: rtl/j17_pkg.sv
// Shared types and encodings for the J17 control unit: opcodes, FSM states,
// ALU codes and the datapath control bundle.
package j17_pkg;

  localparam logic [4:0] OP_ALU_MAX = 5'h0B;
  localparam logic [4:0] OP_ADDI    = 5'h0C;
  localparam logic [4:0] OP_LOAD    = 5'h0D;
  localparam logic [4:0] OP_STORE   = 5'h0E;
  localparam logic [4:0] OP_BR_BASE = 5'h10;
  localparam logic [4:0] OP_HALT    = 5'h1F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_MEM,
    ST_WB,
    ST_EXEC,
    ST_HALT
  } state_e;

  localparam logic [4:0] ALU_NOP  = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_AND  = 5'd3;
  localparam logic [4:0] ALU_OR   = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SLL  = 5'd6;
  localparam logic [4:0] ALU_SRL  = 5'd7;
  localparam logic [4:0] ALU_SRA  = 5'd8;
  localparam logic [4:0] ALU_SLT  = 5'd9;
  localparam logic [4:0] ALU_SLTU = 5'd10;
  localparam logic [4:0] ALU_MUL  = 5'd11;

  localparam logic [2:0] PC_SEQ    = 3'd0;
  localparam logic [1:0] WC_ALU    = 2'd0;
  localparam logic [1:0] WC_MEM    = 2'd1;
  localparam logic [1:0] RAM_IDLE  = 2'b00;
  localparam logic [1:0] RAM_READ  = 2'b01;
  localparam logic [1:0] RAM_WRITE = 2'b10;

  typedef struct packed {
    logic [4:0]  alucode;
    logic [4:0]  op1;
    logic [19:0] op2;
    logic        imcontrol;
    logic [1:0]  writecode;
    logic [2:0]  pccontrol;
  } ctrl_t;

  typedef struct packed {
    logic is_alu;
    logic is_mem;
    logic is_load;
    logic is_branch;
    logic is_halt;
    logic is_illegal;
  } iclass_t;

endpackage

// File: rtl/j17_decoder.sv
// Combinational instruction decoder: maps an instruction word to the
// datapath control values and the class flags the sequencer branches on.
module j17_decoder
  import j17_pkg::*;
(
  input  logic [31:0] ir,
  output logic [4:0]  alucode,
  output logic [4:0]  op1,
  output logic [19:0] op2,
  output logic        imcontrol,
  output logic [1:0]  ramenable,
  output logic [1:0]  writecode,
  output logic [2:0]  pccontrol,
  output logic        is_alu,
  output logic        is_mem,
  output logic        is_load,
  output logic        is_branch,
  output logic        is_halt,
  output logic        is_illegal
);

  logic [4:0] opc;
  logic       unused_ir_bits;

  assign opc            = ir[31:27];
  assign op1            = ir[26:22];
  assign op2            = ir[19:0];
  assign unused_ir_bits = ^ir[21:20];

  always_comb begin
    alucode    = ALU_NOP;
    imcontrol  = 1'b0;
    ramenable  = RAM_IDLE;
    writecode  = WC_ALU;
    pccontrol  = PC_SEQ;
    is_alu     = 1'b0;
    is_mem     = 1'b0;
    is_load    = 1'b0;
    is_branch  = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    if (opc <= OP_ALU_MAX) begin
      alucode = opc;
      is_alu  = 1'b1;
    end else if (opc == OP_ADDI) begin
      alucode   = ALU_ADD;
      imcontrol = 1'b1;
      is_alu    = 1'b1;
    end else if (opc == OP_LOAD) begin
      ramenable = RAM_READ;
      imcontrol = 1'b1;
      writecode = WC_MEM;
      is_mem    = 1'b1;
      is_load   = 1'b1;
    end else if (opc == OP_STORE) begin
      ramenable = RAM_WRITE;
      is_mem    = 1'b1;
    end else if ((opc & 5'h18) == OP_BR_BASE) begin
      pccontrol = opc[2:0];
      is_branch = 1'b1;
    end else if (opc == OP_HALT) begin
      is_halt = 1'b1;
    end else begin
      is_illegal = 1'b1;
    end
  end

endmodule

// File: rtl/j17_control_unit.sv
// J17 multi-cycle sequencer: fetch over req/ack, decode, then step through
// MEM/WB/EXEC with registered control outputs and a retired-instruction count.
module j17_control_unit
  import j17_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [XLEN-1:0]  pc,
  output logic             imem_req,
  output logic [9:0]       imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_data,
  output logic [4:0]       alucode,
  output logic [4:0]       op1,
  output logic [19:0]      op2,
  output logic             imControl,
  output logic             regenable,
  output logic [1:0]       ramenable,
  output logic [1:0]       writecode,
  output logic [2:0]       pcControl,
  output logic             pc_step,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic             imem_req_q, imem_req_d;
  logic [9:0]       imem_addr_q, imem_addr_d;
  ctrl_t            ctrl_q, ctrl_d, dec_ctrl;
  iclass_t          dec_cls;
  logic [1:0]       dec_ramenable;
  logic [1:0]       ramenable_q, ramenable_d;
  logic             regenable_q, regenable_d;
  logic             pc_step_q, pc_step_d;
  logic             halted_q, halted_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             unused_pc_hi;

  assign unused_pc_hi = ^pc[XLEN-1:10];

  // Decoding the word being latched lets the controls be registered on the
  // same edge that leaves FETCH, so they are valid throughout DECODE.
  assign ir_d = (state_q == ST_FETCH && imem_ack) ? imem_data : ir_q;

  j17_decoder u_decoder (
    .ir         (ir_d),
    .alucode    (dec_ctrl.alucode),
    .op1        (dec_ctrl.op1),
    .op2        (dec_ctrl.op2),
    .imcontrol  (dec_ctrl.imcontrol),
    .ramenable  (dec_ramenable),
    .writecode  (dec_ctrl.writecode),
    .pccontrol  (dec_ctrl.pccontrol),
    .is_alu     (dec_cls.is_alu),
    .is_mem     (dec_cls.is_mem),
    .is_load    (dec_cls.is_load),
    .is_branch  (dec_cls.is_branch),
    .is_halt    (dec_cls.is_halt),
    .is_illegal (dec_cls.is_illegal)
  );

  always_comb begin
    state_d     = state_q;
    imem_req_d  = 1'b0;
    imem_addr_d = imem_addr_q;
    ctrl_d      = ctrl_q;
    ramenable_d = RAM_IDLE;
    regenable_d = 1'b0;
    pc_step_d   = 1'b0;
    halted_d    = halted_q;
    illegal_d   = illegal_q;
    retired_d   = retired_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_FETCH;
          imem_req_d  = 1'b1;
          imem_addr_d = pc[9:0];
        end
      end
      ST_FETCH: begin
        if (imem_ack) begin
          state_d = ST_DECODE;
          ctrl_d  = dec_ctrl;
        end else begin
          imem_req_d = 1'b1;
        end
      end
      ST_DECODE: begin
        if (dec_cls.is_branch) begin
          state_d   = ST_EXEC;
          pc_step_d = 1'b1;
          retired_d = retired_q + CNT_W'(1);
        end else if (dec_cls.is_mem) begin
          state_d     = ST_MEM;
          ramenable_d = dec_ramenable;
        end else if (dec_cls.is_alu) begin
          state_d     = ST_WB;
          regenable_d = 1'b1;
        end else begin
          state_d   = ST_HALT;
          halted_d  = 1'b1;
          illegal_d = dec_cls.is_illegal;
        end
      end
      ST_MEM: begin
        if (dec_cls.is_load) begin
          state_d     = ST_WB;
          regenable_d = 1'b1;
        end else begin
          state_d   = ST_EXEC;
          pc_step_d = 1'b1;
          retired_d = retired_q + CNT_W'(1);
        end
      end
      ST_WB: begin
        state_d   = ST_EXEC;
        pc_step_d = 1'b1;
        retired_d = retired_q + CNT_W'(1);
      end
      ST_EXEC: begin
        state_d     = ST_FETCH;
        imem_req_d  = 1'b1;
        imem_addr_d = pc[9:0];
      end
      ST_HALT: begin
        if (start) begin
          state_d     = ST_FETCH;
          imem_req_d  = 1'b1;
          imem_addr_d = pc[9:0];
          halted_d    = 1'b0;
          illegal_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ir_q        <= '0;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      ctrl_q      <= '0;
      ramenable_q <= RAM_IDLE;
      regenable_q <= 1'b0;
      pc_step_q   <= 1'b0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      ctrl_q      <= ctrl_d;
      ramenable_q <= ramenable_d;
      regenable_q <= regenable_d;
      pc_step_q   <= pc_step_d;
      halted_q    <= halted_d;
      illegal_q   <= illegal_d;
      retired_q   <= retired_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign alucode   = ctrl_q.alucode;
  assign op1       = ctrl_q.op1;
  assign op2       = ctrl_q.op2;
  assign imControl = ctrl_q.imcontrol;
  assign writecode = ctrl_q.writecode;
  assign pcControl = ctrl_q.pccontrol;
  assign ramenable = ramenable_q;
  assign regenable = regenable_q;
  assign pc_step   = pc_step_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_j17_control_unit.sv
// Scoreboard bench for j17_control_unit (CNT_W=4 so the retired counter wraps).
// A driver issues random instructions and queues expectations; a monitor checks each instruction window.
module tb_j17_control_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset, start, imem_ack;
  logic [XLEN-1:0]  pc;
  logic [31:0]      imem_data;
  logic             imem_req, imControl, regenable, pc_step, halted, illegal;
  logic [9:0]       imem_addr;
  logic [4:0]       alucode, op1;
  logic [19:0]      op2;
  logic [1:0]       ramenable, writecode;
  logic [2:0]       pcControl;
  logic [CNT_W-1:0] retired;

  j17_control_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .start(start), .pc(pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .alucode(alucode), .op1(op1), .op2(op2), .imControl(imControl),
    .regenable(regenable), .ramenable(ramenable), .writecode(writecode), .pcControl(pcControl),
    .pc_step(pc_step), .halted(halted), .illegal(illegal), .retired(retired)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          halts;
    bit          ill;
    int          cycles;
    int          n_reg;
    int          n_ram;
    logic [1:0]  ram;
    logic [4:0]  alu;
    logic [4:0]  o1;
    logic [19:0] o2;
    logic        imc;
    logic [1:0]  wc;
    logic [2:0]  pcc;
    int          ret;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   model_ret = 0;
  bit   running = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour straight from the opcode table and cycle budgets.
  function automatic exp_t model(input logic [31:0] instr, input int waits);
    exp_t e;
    int   op;
    e    = '{default: 0};
    op   = int'(instr[31:27]);
    e.o1 = instr[26:22];
    e.o2 = instr[19:0];
    if (op <= 11) begin
      e.alu = 5'(op); e.n_reg = 1; e.cycles = 4;
    end else if (op == 12) begin
      e.alu = 5'd1; e.imc = 1'b1; e.n_reg = 1; e.cycles = 4;
    end else if (op == 13) begin
      e.imc = 1'b1; e.wc = 2'd1; e.ram = 2'b01; e.n_ram = 1; e.n_reg = 1; e.cycles = 5;
    end else if (op == 14) begin
      e.ram = 2'b10; e.n_ram = 1; e.cycles = 4;
    end else if (op >= 16 && op <= 23) begin
      e.pcc = 3'(op - 16); e.cycles = 3;
    end else begin
      // FETCH, DECODE and the first cycle showing halted
      e.halts = 1'b1; e.ill = (op != 31); e.cycles = 3;
    end
    e.cycles += waits;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    int r, op;
    r = $urandom_range(0, 99);
    if (r < 45)      op = $urandom_range(0, 11);
    else if (r < 55) op = 12;
    else if (r < 65) op = 13;
    else if (r < 75) op = 14;
    else if (r < 92) op = $urandom_range(16, 23);
    else if (r < 96) op = 31;
    else             op = $urandom_range(0, 7) == 0 ? 15 : $urandom_range(24, 30);
    return {5'(op), 27'($urandom)};
  endfunction

  task automatic issue(input logic [31:0] instr, input int waits, input bit abort_mid);
    exp_t       e;
    int         n;
    logic [9:0] exp_addr;
    e = model(instr, waits);
    n = 0;
    while (imem_req !== 1'b1 && n < 40) begin
      pc        = $urandom;
      imem_ack  = 1'($urandom_range(0, 1));
      imem_data = $urandom;
      start     = running ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clock);
      n++;
    end
    chk("fetch_req", {63'd0, imem_req}, 64'd1);
    exp_addr = pc[9:0];
    imem_ack = 1'b0;
    start    = running ? 1'($urandom_range(0, 1)) : 1'b0;
    chk("imem_addr", {54'd0, imem_addr}, {54'd0, exp_addr});
    if (!e.halts && !abort_mid) model_ret = (model_ret + 1) % (1 << CNT_W);
    e.ret = model_ret;
    if (!abort_mid) sb.push_back(e);
    for (int i = 0; i < waits; i++) begin
      pc = $urandom;
      @(negedge clock);
      chk("imem_addr_hold", {54'd0, imem_addr}, {54'd0, exp_addr});
    end
    imem_ack  = 1'b1;
    imem_data = instr;
    @(negedge clock);
    imem_ack  = 1'b0;
    imem_data = $urandom;
    running   = !e.halts;
    if (e.halts) begin
      start = 1'b0;
      n = 0;
      while (halted !== 1'b1 && n < 10) begin
        @(negedge clock);
        n++;
      end
      chk("halt_seen", {63'd0, halted}, 64'd1);
      repeat ($urandom_range(1, 3)) @(negedge clock);
      chk("halt_stays", {63'd0, halted}, 64'd1);
    end
    if (abort_mid) begin
      @(negedge clock);
      #2 reset = 1'b1;
      #1 chk("abort_outputs", {60'd0, pc_step, regenable, ramenable}, 64'd0);
      chk("abort_retired", {60'd0, retired}, 64'd0);
      @(negedge clock);
      #2 reset = 1'b0;
      model_ret = 0;
      running   = 1'b0;
      start     = 1'b0;
    end
  endtask

  // Monitor: one window per instruction, from first FETCH cycle to pc_step or halted.
  bit          win = 1'b0;
  bit          dec_seen, ret_pend = 1'b0;
  int          cyc, n_reg, n_ram, reg_cyc, ram_cyc, ret_exp;
  logic [1:0]  ram_v, reg_wc;
  logic [37:0] dec_snap;

  always @(negedge clock) begin
    exp_t e;
    logic [37:0] exp_ctl;
    if (reset) begin
      win      = 1'b0;
      ret_pend = 1'b0;
    end else begin
      if (ret_pend) begin
        chk("retired", {60'd0, retired}, 64'(ret_exp));
        ret_pend = 1'b0;
      end
      if (!win && imem_req === 1'b1) begin
        win = 1'b1; cyc = 0; n_reg = 0; n_ram = 0; reg_cyc = 0; ram_cyc = 0;
        dec_seen = 1'b0; ram_v = 2'b00; reg_wc = 2'b00; dec_snap = '0;
        chk("fetch_illegal_clear", {63'd0, illegal}, 64'd0);
        chk("fetch_halted_clear", {63'd0, halted}, 64'd0);
      end
      if (win) begin
        cyc++;
        if (!dec_seen && imem_req === 1'b0) begin
          dec_seen = 1'b1;
          dec_snap = {alucode, op1, op2, imControl, writecode, pcControl};
        end
        if (regenable) begin n_reg++; reg_cyc = cyc; reg_wc = writecode; end
        if (ramenable != 2'b00) begin n_ram++; ram_cyc = cyc; ram_v = ramenable; end
        if (pc_step || halted) begin
          win = 1'b0;
          if (sb.size() == 0) begin
            chk("sb_underflow", 64'(sb.size()), 64'd1);
          end else begin
            e = sb.pop_front();
            exp_ctl = {e.alu, e.o1, e.o2, e.imc, e.wc, e.pcc};
            chk("end_kind", {62'd0, halted, pc_step}, e.halts ? 64'd2 : 64'd1);
            chk("cycles", 64'(cyc), 64'(e.cycles));
            chk("regenable_pulses", 64'(n_reg), 64'(e.n_reg));
            chk("ramenable_pulses", 64'(n_ram), 64'(e.n_ram));
            chk("illegal", {63'd0, illegal}, {63'd0, e.ill});
            if (e.halts) begin
              chk("halt_retired", {60'd0, retired}, 64'(e.ret));
            end else begin
              chk("step_vs_reg", {63'd0, regenable}, 64'd0);
              chk("ctl_decode", {26'd0, dec_snap}, {26'd0, exp_ctl});
              chk("ctl_exec", {26'd0, alucode, op1, op2, imControl, writecode, pcControl},
                  {26'd0, exp_ctl});
              if (e.n_ram > 0) chk("ram_value", {62'd0, ram_v}, {62'd0, e.ram});
              if (e.n_reg > 0) begin
                chk("reg_writecode", {62'd0, reg_wc}, {62'd0, e.wc});
                chk("reg_before_step", 64'(reg_cyc), 64'(cyc - 1));
              end
              if (e.n_ram > 0)
                chk("ram_slot", 64'(ram_cyc), 64'(cyc - (e.n_reg > 0 ? 2 : 1)));
              ret_pend = 1'b1;
              ret_exp  = e.ret;
            end
          end
        end
      end else if (pc_step || regenable || ramenable != 2'b00) begin
        chk("stray_pulse", {60'd0, pc_step, regenable, ramenable}, 64'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; pc = '0; imem_ack = 1'b0; imem_data = '0;
    repeat (3) @(negedge clock);
    chk("rst_outputs", {imem_req, imem_addr, alucode, op1, op2, imControl, regenable,
                        ramenable, writecode, pcControl, pc_step, halted, illegal},
        64'd0);
    chk("rst_retired", {60'd0, retired}, 64'd0);
    #2 reset = 1'b0;
    @(negedge clock);

    // Reset while a fetch is pending.
    n = 0;
    while (imem_req !== 1'b1 && n < 10) begin
      start = 1'b1; pc = 32'h0000_03A5;
      @(negedge clock);
      n++;
    end
    chk("midfetch_req", {63'd0, imem_req}, 64'd1);
    start = 1'b0;
    #2 reset = 1'b1;
    #1 chk("midfetch_rst", {imem_req, imem_addr, alucode, op1, op2, imControl, regenable,
                            ramenable, writecode, pcControl, pc_step, halted, illegal},
           64'd0);
    @(negedge clock);
    #2 reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("idle_no_req", {63'd0, imem_req}, 64'd0);

    issue(32'h0840_0000, 2, 1'b0);              // ADD r1, two wait cycles
    issue(32'h6800_0005, 0, 1'b0);              // LOAD op2=5
    issue(32'h9000_0000 | 32'h0055_1234, 0, 1'b0); // branch, pcControl=2
    issue(32'hD800_0000, 1, 1'b0);              // opcode 0x1B is illegal
    issue(32'h0840_0000, 0, 1'b0);              // resumes after start
    issue(32'h7000_0042, 1, 1'b0);              // STORE
    issue(32'hF800_0000, 0, 1'b0);              // HALT
    issue(32'h0840_0000, 0, 1'b1);              // aborted in WB by reset
    for (int i = 0; i < 70; i++) issue(rand_instr(), $urandom_range(0, 3), 1'b0);

    start = 1'b0;
    repeat (8) @(negedge clock);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
